// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller: source count,
// register map and the 2-bit priority type (priority 0 means masked).
package irq_pkg;
  localparam int NUM_SRC = 16;
  localparam int VEC_W   = 4;
  localparam int ADDR_W  = 24;

  typedef logic [1:0] pri_t;
  localparam pri_t PRI_MASKED = 2'd0;

  localparam logic [ADDR_W-1:0] ADDR_ENABLE_LO = 24'h002020;
  localparam logic [ADDR_W-1:0] ADDR_ENABLE_HI = 24'h002021;
  localparam logic [ADDR_W-1:0] ADDR_FLAG_LO   = 24'h002022;
  localparam logic [ADDR_W-1:0] ADDR_FLAG_HI   = 24'h002023;
  localparam logic [ADDR_W-1:0] ADDR_PRI0      = 24'h002024;
  localparam logic [ADDR_W-1:0] ADDR_PRI1      = 24'h002025;
  localparam logic [ADDR_W-1:0] ADDR_PRI2      = 24'h002026;
  localparam logic [ADDR_W-1:0] ADDR_PRI3      = 24'h002027;
endpackage

// File: rtl/irq_edge_sync.sv
// Synchronises one interrupt line into the clk domain and emits a one-cycle
// pulse on each genuine low-to-high transition.
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_line,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] valid_q;
  logic                   prev_q;
  logic                   armed_q;

  // valid_q tracks which synchroniser stages hold real post-reset samples, so
  // the zeros loaded by reset never count as a low; a line held high across
  // reset must therefore be seen low before its next rise is reported.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      valid_q <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_line};
      valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= sync_q[SYNC_STAGES-1];
      if (valid_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1])
        armed_q <= 1'b1;
    end
  end

  assign rise = armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/irq_controller.sv
// Sixteen-source prioritised interrupt controller with a byte-wide register
// bus for enables, pending flags (write-1-to-clear) and per-source priorities.
module irq_controller
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_write,
  input  logic              bus_read,
  input  logic [ADDR_W-1:0] bus_address_in,
  input  logic [7:0]        bus_data_in,
  output logic [7:0]        bus_data_out,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic              irq_ack,
  output logic              irq_req,
  output logic [VEC_W-1:0]  irq_vector,
  output pri_t              irq_pri
);
  logic [NUM_SRC-1:0]   enable_q;
  logic [NUM_SRC-1:0]   flag_q;
  logic [2*NUM_SRC-1:0] pri_q;
  logic [NUM_SRC-1:0]   set_pulse;
  logic [NUM_SRC-1:0]   clear_mask;
  logic [VEC_W-1:0]     best_idx;
  pri_t                 best_pri;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .irq_line (irq_in[g]),
      .rise     (set_pulse[g])
    );
  end

  // Strictly-greater scan from index 0 gives lowest-index tie-break, and
  // starting at zero excludes priority-0 sources automatically.
  always_comb begin
    best_idx = '0;
    best_pri = PRI_MASKED;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (flag_q[i] && enable_q[i] && (pri_q[2*i +: 2] > best_pri)) begin
        best_pri = pri_q[2*i +: 2];
        best_idx = i[VEC_W-1:0];
      end
    end
  end

  always_comb begin
    clear_mask = '0;
    if (irq_ack && irq_req)
      clear_mask[irq_vector] = 1'b1;
    if (bus_write && (bus_address_in == ADDR_FLAG_LO))
      clear_mask[7:0] = clear_mask[7:0] | bus_data_in;
    if (bus_write && (bus_address_in == ADDR_FLAG_HI))
      clear_mask[15:8] = clear_mask[15:8] | bus_data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q   <= '0;
      pri_q      <= '0;
      flag_q     <= '0;
      irq_req    <= 1'b0;
      irq_vector <= '0;
      irq_pri    <= PRI_MASKED;
    end else begin
      if (bus_write) begin
        case (bus_address_in)
          ADDR_ENABLE_LO: enable_q[7:0]  <= bus_data_in;
          ADDR_ENABLE_HI: enable_q[15:8] <= bus_data_in;
          ADDR_PRI0:      pri_q[7:0]     <= bus_data_in;
          ADDR_PRI1:      pri_q[15:8]    <= bus_data_in;
          ADDR_PRI2:      pri_q[23:16]   <= bus_data_in;
          ADDR_PRI3:      pri_q[31:24]   <= bus_data_in;
          default: ;
        endcase
      end
      flag_q     <= (flag_q & ~clear_mask) | set_pulse;
      irq_req    <= (best_pri != PRI_MASKED);
      irq_vector <= best_idx;
      irq_pri    <= best_pri;
    end
  end

  // The read bus idles at zero whenever no read strobe is present.
  always_comb begin
    bus_data_out = 8'h00;
    if (bus_read) begin
      case (bus_address_in)
        ADDR_ENABLE_LO: bus_data_out = enable_q[7:0];
        ADDR_ENABLE_HI: bus_data_out = enable_q[15:8];
        ADDR_FLAG_LO:   bus_data_out = flag_q[7:0];
        ADDR_FLAG_HI:   bus_data_out = flag_q[15:8];
        ADDR_PRI0:      bus_data_out = pri_q[7:0];
        ADDR_PRI1:      bus_data_out = pri_q[15:8];
        ADDR_PRI2:      bus_data_out = pri_q[23:16];
        ADDR_PRI3:      bus_data_out = pri_q[31:24];
        default:        bus_data_out = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: a register-level behavioural model checked every
// cycle, plus directed sequences with hand-computed expectations.
module tb_irq_controller;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [23:0] bus_address_in = '0;
  logic [7:0]  bus_data_in = '0;
  logic [7:0]  bus_data_out;
  logic [15:0] irq_in = '0;
  logic        irq_ack = 1'b0;
  logic        irq_req;
  logic [3:0]  irq_vector;
  logic [1:0]  irq_pri;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  irq_controller #(.SYNC_STAGES(S)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .irq_in         (irq_in),
    .irq_ack        (irq_ack),
    .irq_req        (irq_req),
    .irq_vector     (irq_vector),
    .irq_pri        (irq_pri)
  );

  always #5 clk = ~clk;

  // Model state: registers as arrays, sampled input history as a queue.
  logic [15:0] m_en;
  logic [15:0] m_flag;
  int          m_pri [16];
  logic [15:0] hist [$];
  logic        exp_req;
  logic [3:0]  exp_vec;
  logic [1:0]  exp_pri;

  function automatic logic [7:0] model_read(input logic [23:0] a);
    logic [7:0] b;
    b = 8'h00;
    case (a)
      24'h2020: b = m_en[7:0];
      24'h2021: b = m_en[15:8];
      24'h2022: b = m_flag[7:0];
      24'h2023: b = m_flag[15:8];
      24'h2024, 24'h2025, 24'h2026, 24'h2027:
        for (int j = 0; j < 4; j++)
          b[2*j +: 2] = 2'(m_pri[4*(a - 24'h2024) + j]);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Walk priority levels from highest down, lowest index first within a level.
  task automatic model_select(output logic r, output logic [3:0] v, output logic [1:0] p);
    r = 1'b0; v = '0; p = '0;
    for (int lvl = 3; lvl >= 1; lvl--)
      for (int i = 0; i < 16; i++)
        if (!r && m_flag[i] && m_en[i] && m_pri[i] == lvl) begin
          r = 1'b1; v = 4'(i); p = 2'(lvl);
        end
  endtask

  always @(posedge clk) begin
    logic        nr;
    logic [3:0]  nv;
    logic [1:0]  np;
    logic [15:0] clr;
    logic [15:0] set;
    int          len;
    if (reset) begin
      m_en = '0; m_flag = '0;
      for (int i = 0; i < 16; i++) m_pri[i] = 0;
      hist.delete();
      exp_req = 1'b0; exp_vec = '0; exp_pri = '0;
    end else begin
      model_select(nr, nv, np);
      clr = '0;
      if (irq_ack && exp_req) clr[exp_vec] = 1'b1;
      if (bus_write) begin
        case (bus_address_in)
          24'h2020: m_en[7:0] = bus_data_in;
          24'h2021: m_en[15:8] = bus_data_in;
          24'h2022: clr[7:0] = clr[7:0] | bus_data_in;
          24'h2023: clr[15:8] = clr[15:8] | bus_data_in;
          24'h2024, 24'h2025, 24'h2026, 24'h2027:
            for (int j = 0; j < 4; j++)
              m_pri[4*(bus_address_in - 24'h2024) + j] = int'(bus_data_in[2*j +: 2]);
          default: ;
        endcase
      end
      // A rise is a 0 then 1 pair among samples taken S and S+1 edges ago.
      set = '0;
      len = hist.size();
      if (len >= S + 1) set = hist[len-S] & ~hist[len-S-1];
      m_flag = (m_flag & ~clr) | set;
      hist.push_back(irq_in);
      if (hist.size() > S + 1) void'(hist.pop_front());
      exp_req = nr; exp_vec = nv; exp_pri = np;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_output("model_irq_req", 32'(irq_req), 32'(exp_req));
      check_output("model_irq_vector", 32'(irq_vector), 32'(exp_vec));
      check_output("model_irq_pri", 32'(irq_pri), 32'(exp_pri));
      if (bus_read)
        check_output("model_bus_data_out", 32'(bus_data_out), 32'(model_read(bus_address_in)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [23:0] a, input logic [7:0] d);
    bus_write = 1'b1; bus_address_in = a; bus_data_in = d;
    step();
    bus_write = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [23:0] a, input logic [7:0] exp);
    bus_read = 1'b1; bus_address_in = a;
    @(negedge clk);
    check_output(name, 32'(bus_data_out), 32'(exp));
    step();
    bus_read = 1'b0;
  endtask

  task automatic check_irq(input string name, input logic r, input logic [3:0] v, input logic [1:0] p);
    @(negedge clk);
    check_output({name, "_req"}, 32'(irq_req), 32'(r));
    check_output({name, "_vec"}, 32'(irq_vector), 32'(v));
    check_output({name, "_pri"}, 32'(irq_pri), 32'(p));
    step();
  endtask

  task automatic pulse(input logic [15:0] lines);
    irq_in = lines;
    step();
    irq_in = '0;
    repeat (4) step();
  endtask

  initial begin
    int lat;
    step();
    check_en = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    check_irq("reset_state", 1'b0, 4'd0, 2'd0);
    read_check("reset_enable", 24'h2020, 8'h00);

    // Single source latency and presentation.
    apply_stimulus(24'h2020, 8'h01);
    apply_stimulus(24'h2024, 8'h03);
    irq_in[0] = 1'b1;
    step();
    irq_in[0] = 1'b0;
    lat = 1;
    while (lat < 12) begin
      @(negedge clk);
      if (irq_req) break;
      step();
      lat++;
    end
    check_output("latency_src0", 32'(lat), 32'(S + 2));
    check_output("latency_vec", 32'(irq_vector), 32'd0);
    check_output("latency_pri", 32'(irq_pri), 32'd3);
    step();
    read_check("flag_src0", 24'h2022, 8'h01);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    repeat (3) step();

    // Higher priority first, then the remaining source after ack.
    apply_stimulus(24'h2020, 8'h24);
    apply_stimulus(24'h2024, 8'h13);
    apply_stimulus(24'h2025, 8'h08);
    pulse(16'h0024);
    check_irq("prio_first", 1'b1, 4'd5, 2'd2);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    read_check("flag_after_ack", 24'h2022, 8'h04);
    check_irq("prio_second", 1'b1, 4'd2, 2'd1);

    // Equal priority: lowest index wins.
    apply_stimulus(24'h2022, 8'hFF);
    apply_stimulus(24'h2023, 8'hFF);
    apply_stimulus(24'h2020, 8'h08);
    apply_stimulus(24'h2021, 8'h02);
    apply_stimulus(24'h2024, 8'h80);
    apply_stimulus(24'h2026, 8'h08);
    pulse(16'h0208);
    check_irq("tie_first", 1'b1, 4'd3, 2'd2);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    step();
    check_irq("tie_second", 1'b1, 4'd9, 2'd2);

    // Set and W1C on the same edge: the set survives.
    apply_stimulus(24'h2022, 8'hFF);
    apply_stimulus(24'h2023, 8'hFF);
    apply_stimulus(24'h2020, 8'h01);
    apply_stimulus(24'h2024, 8'h03);
    pulse(16'h0001);
    read_check("flag_before_collide", 24'h2022, 8'h01);
    irq_in[0] = 1'b1; step();
    irq_in[0] = 1'b0; step();
    apply_stimulus(24'h2022, 8'h01);
    read_check("set_beats_w1c", 24'h2022, 8'h01);

    // Pending but disabled, then enabled.
    apply_stimulus(24'h2022, 8'hFF);
    apply_stimulus(24'h2020, 8'h00);
    apply_stimulus(24'h2025, 8'h01);
    pulse(16'h0010);
    check_irq("disabled_pending", 1'b0, 4'd0, 2'd0);
    read_check("flag_disabled", 24'h2022, 8'h10);
    apply_stimulus(24'h2020, 8'h10);
    step();
    check_irq("enabled_late", 1'b1, 4'd4, 2'd1);

    // Reset during an active request.
    reset = 1'b1; step();
    check_irq("reset_mid_req", 1'b0, 4'd0, 2'd0);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) read_check("reset_regs", 24'h2020 + 24'(a), 8'h00);

    // Line held high across reset must not set; re-arms after a low.
    irq_in = 16'h0002; repeat (3) step();
    reset = 1'b1; repeat (3) step(); reset = 1'b0;
    apply_stimulus(24'h2020, 8'hFF);
    apply_stimulus(24'h2024, 8'hFF);
    repeat (6) step();
    read_check("held_over_reset", 24'h2022, 8'h00);
    check_irq("held_over_reset", 1'b0, 4'd0, 2'd0);
    irq_in = 16'h0000; repeat (4) step();
    irq_in = 16'h0002; repeat (6) step();
    read_check("rearmed", 24'h2022, 8'h02);
    apply_stimulus(24'h2022, 8'h02);
    repeat (6) step();
    read_check("held_sets_once", 24'h2022, 8'h00);
    irq_in = 16'h0000;

    // Unmapped addresses.
    apply_stimulus(24'h2028, 8'hFF);
    read_check("unmapped_read", 24'h2028, 8'h00);
    read_check("unmapped_upper", 24'h012020, 8'h00);
    apply_stimulus(24'h012020, 8'h00);
    read_check("unmapped_write", 24'h2020, 8'hFF);

    // Mixed traffic checked by the model alone.
    for (int c = 0; c < 300; c++) begin
      irq_in = irq_in ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      bus_write = ($urandom_range(0, 3) == 0);
      bus_read = !bus_write;
      bus_address_in = 24'h2020 + 24'($urandom_range(0, 8));
      bus_data_in = 8'($urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      step();
    end
    bus_write = 1'b0; bus_read = 1'b0; irq_ack = 1'b0; irq_in = '0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
